pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-side controller that sequences the 32-bit program-counter register.
- Owns no PC storage itself. Reads the current PC (pc_cur) and drives the PC register's load enable (pc_ena) and load value (pc_next).
- Issues instruction-memory fetch requests and handles stalls, branch/jump/exception redirects and halt.
- Sits between the PC register, instruction memory and the decode/hazard/exception logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on the first cycle after reset release.
- EXC_VECTOR, 32'h0000_0004, PC loaded on an exception.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low: asserted when low at a posedge.
- pc_cur  in  32  current value of the PC register.
- imem_ack  in  1  instruction memory returns the word for imem_addr this cycle.
- stall  in  1  downstream cannot accept an instruction this cycle.
- br_taken  in  1  branch resolved taken (1-cycle pulse).
- br_target  in  32  branch target.
- jmp_valid  in  1  jump request (1-cycle pulse).
- jmp_target  in  32  jump target.
- exc_req  in  1  exception request (1-cycle pulse).
- halt  in  1  stop fetching (level).
- pc_ena  out  1  PC register load enable.
- pc_next  out  32  PC register load value.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc_cur.
- fetch_valid  out  1  fetched instruction accepted downstream this cycle.
- halted  out  1  block is in HALTED.

Behaviour:
- **Reset**
  - rst low at a posedge: state goes to BOOT; pending redirect is cleared.
  - While state is BOOT and rst is low, all outputs are 0.
  - Reset mid-fetch aborts the fetch with no PC update.
- **States:** BOOT, FETCH, STALL, HALTED.
- **BOOT** (first cycle with rst high): pc_ena=1, pc_next=RESET_PC, then go to FETCH.
- **FETCH**
  - imem_req=1; imem_addr=pc_cur; req stays held until imem_ack.
  - On ack with no redirect (new or pending) and stall=0: fetch_valid=1, pc_ena=1, pc_next=pc_cur+PC_STEP. Stay in FETCH; next fetch is requested the following cycle.
  - On ack with no redirect and stall=1: no PC update, fetch_valid=0, go to STALL.
  - On ack with a redirect (new this cycle or pending): fetch_valid=0 (fetched word squashed), pc_ena=1, pc_next=redirect target, pending cleared.
  - Redirect while ack=0: latch target into the pending register; no PC update until ack (the outstanding fetch must complete).
- **STALL**
  - imem_req=0; instruction is held externally.
  - stall falls: fetch_valid=1, pc_ena=1, pc_next=pc_cur+PC_STEP, go to FETCH.
  - Redirect arrives: fetch_valid=0, pc_ena=1, pc_next=target, go to FETCH; redirect beats stall.
- **Redirect priority** (same cycle): exc_req > jmp_valid > br_taken.
  - A pending exception is never overwritten.
  - A pending jump/branch is overwritten by any later redirect.
- **HALTED**
  - halt=1 is sampled at a completed-instruction boundary: after fetch_valid pulses, go to HALTED.
  - In HALTED, imem_req=0 and halted=1.
  - Exit only via reset or exc_req (load EXC_VECTOR, go to FETCH); halt is ignored while exc_req is asserted.
- **Arithmetic**
  - pc_cur+PC_STEP is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - Bits [1:0] of every target are forced to 0.
- **pc_ena** is high for at most one cycle per accepted instruction or redirect; never high in STALL without a redirect.
- **pc_next** is 0 whenever pc_ena=0.

Decomposition:
- Shared package holds:
  - State enum (BOOT/FETCH/STALL/HALTED, 2-bit).
  - Redirect-kind encoding (NONE/BR/JMP/EXC).
  - Constants RESET_PC, EXC_VECTOR, PC_STEP defaults.
- One combinational sub-module, next_pc_select: priority mux producing target and kind from exc/jmp/br inputs plus the pending register, with alignment masking.
- FSM and pending register stay in pc_sequencer.

Test Plan:
- Boot: rst low 2 cycles then high, imem_ack tied 1 -> pc_ena pulses with pc_next=0x0; subsequent cycles pc_next=0x4, 0x8, 0xC with fetch_valid=1.
- Slow memory: ack 3 cycles after req at pc_cur=0x10, br_taken pulse (target 0x40) in cycle 1 -> no pc_ena until ack; on ack pc_next=0x40, fetch_valid=0.
- Priority: br_taken (0x100), jmp_valid (0x200), exc_req same cycle -> pc_next=EXC_VECTOR 0x4; later jmp while exception pending does not replace it.
- Stall: ack at pc_cur=0x20 with stall=1 for 4 cycles -> pc_ena=0, imem_req=0; stall falls -> fetch_valid=1, pc_next=0x24.
- Wrap/align: pc_cur=0xFFFF_FFFC ack -> pc_next=0x0; jmp_target=0x0000_0103 -> pc_next=0x0000_0100.
- Halt/reset mid-op: halt=1 -> halted=1 after next fetch_valid; exc_req -> pc_next=0x4, FETCH; rst low during pending redirect -> all outputs 0, pending cleared, then BOOT reloads 0x0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
//   state_t      : sequencer FSM state (2-bit)
//   redir_kind_t : redirect source encoding (NONE/BR/JMP/EXC)
//   *_DEF        : default values for the top-level parameters
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'h0000_0004;
    localparam int unsigned     PC_STEP_DEF    = 4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RK_NONE = 2'd0,
        RK_BR   = 2'd1,
        RK_JMP  = 2'd2,
        RK_EXC  = 2'd3
    } redir_kind_t;

    // Clear the two low bits so every target is word aligned.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_select.sv
// Redirect priority mux: picks the winning redirect among the pending
// register and this cycle's exc/jmp/br requests, and aligns its target.
//   exc_req, jmp_valid/jmp_target, br_taken/br_target : new requests
//   pend_kind/pend_target                              : pending redirect
//   sel_kind_c/sel_target_c                            : winning redirect
module next_pc_select
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic              exc_req,
    input  logic              jmp_valid,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  redir_kind_t       pend_kind,
    input  logic [PC_W-1:0]   pend_target,
    output redir_kind_t       sel_kind_c,
    output logic [PC_W-1:0]   sel_target_c
);

    logic [PC_W-1:0] raw_target;

    // A pending exception is sticky; a pending jmp/br loses to anything new.
    always_comb begin
        sel_kind_c = pend_kind;
        raw_target = pend_target;
        if (pend_kind != RK_EXC) begin
            if (exc_req) begin
                sel_kind_c = RK_EXC;
                raw_target = EXC_VECTOR;
            end else if (jmp_valid) begin
                sel_kind_c = RK_JMP;
                raw_target = jmp_target;
            end else if (br_taken) begin
                sel_kind_c = RK_BR;
                raw_target = br_target;
            end
        end
        sel_target_c = align_pc(raw_target);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: drives the external PC register's load
// enable/value, issues instruction fetches, and handles stall, redirect
// (branch/jump/exception) and halt.
//   clk, rst (sync, active-low)
//   pc_cur                 : current PC register value
//   imem_ack / imem_req / imem_addr : instruction memory handshake
//   stall                  : downstream back-pressure
//   br_*, jmp_*, exc_req   : redirect requests
//   halt / halted          : stop fetching / halted status
//   pc_ena / pc_next       : PC register load enable / value
//   fetch_valid            : fetched instruction accepted this cycle
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned     PC_STEP    = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_cur,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jmp_valid,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic              exc_req,
    input  logic              halt,
    output logic              pc_ena,
    output logic [PC_W-1:0]   pc_next,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    output logic              fetch_valid,
    output logic              halted
);

    state_t           state_q, state_d;
    redir_kind_t      pend_kind_q;
    logic [PC_W-1:0]  pend_target_q;
    logic             pend_load, pend_clr;

    redir_kind_t      sel_kind;
    logic [PC_W-1:0]  sel_target;
    logic             redir;
    logic [PC_W-1:0]  pc_inc;

    next_pc_select #(
        .EXC_VECTOR   (EXC_VECTOR)
    ) u_sel (
        .exc_req      (exc_req),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pend_kind    (pend_kind_q),
        .pend_target  (pend_target_q),
        .sel_kind_c   (sel_kind),
        .sel_target_c (sel_target)
    );

    assign redir  = (sel_kind != RK_NONE);
    assign pc_inc = pc_cur + PC_W'(PC_STEP);

    // State and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pend_kind_q   <= RK_NONE;
            pend_target_q <= '0;
        end else begin
            state_q <= state_d;
            if (pend_load) begin
                pend_kind_q   <= sel_kind;
                pend_target_q <= sel_target;
            end else if (pend_clr) begin
                pend_kind_q   <= RK_NONE;
                pend_target_q <= '0;
            end
        end
    end

    // Next state and pending-register control.
    always_comb begin
        state_d   = state_q;
        pend_load = 1'b0;
        pend_clr  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    pend_clr = 1'b1;
                    if (redir)      state_d = ST_FETCH;
                    else if (stall) state_d = ST_STALL;
                    else if (halt)  state_d = ST_HALTED;
                end else if (redir) begin
                    // Outstanding fetch must finish; remember where to go.
                    pend_load = 1'b1;
                end
            end
            ST_STALL: begin
                if (redir) begin
                    pend_clr = 1'b1;
                    state_d  = ST_FETCH;
                end else if (!stall) begin
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (exc_req) state_d = ST_FETCH;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Outputs; everything is forced low while reset is asserted.
    always_comb begin
        pc_ena      = 1'b0;
        pc_next     = '0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            imem_addr = pc_cur;
            case (state_q)
                ST_BOOT: begin
                    pc_ena  = 1'b1;
                    pc_next = RESET_PC;
                end
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (redir) begin
                            pc_ena  = 1'b1;
                            pc_next = sel_target;
                        end else if (!stall) begin
                            fetch_valid = 1'b1;
                            pc_ena      = 1'b1;
                            pc_next     = pc_inc;
                        end
                    end
                end
                ST_STALL: begin
                    if (redir) begin
                        pc_ena  = 1'b1;
                        pc_next = sel_target;
                    end else if (!stall) begin
                        fetch_valid = 1'b1;
                        pc_ena      = 1'b1;
                        pc_next     = pc_inc;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                    if (exc_req) begin
                        pc_ena  = 1'b1;
                        pc_next = align_pc(EXC_VECTOR);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur = 32'hDEAD_BEEF;
    logic        imem_ack, stall, br_taken, jmp_valid, exc_req, halt;
    logic [31:0] br_target, jmp_target;
    logic        pc_ena, imem_req, fetch_valid, halted;
    logic [31:0] pc_next, imem_addr;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Behavioural PC register owned by the environment.
    always @(posedge clk) if (pc_ena) pc_cur <= pc_next;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .exc_req     (exc_req),
        .halt        (halt),
        .pc_ena      (pc_ena),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .fetch_valid (fetch_valid),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        exc_req = 1'b0; halt = 1'b0; br_target = '0; jmp_target = '0;

        // Reset held for two edges: everything low.
        tick(); tick(); settle();
        chk("rst_pc_ena", 32'(pc_ena), 0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_fv", 32'(fetch_valid), 0);
        chk("rst_halted", 32'(halted), 0);

        // Boot then sequential fetch with ack tied high.
        rst = 1'b1; settle();
        chk("boot_pc_ena", 32'(pc_ena), 1);
        chk("boot_pc_next", pc_next, 32'h0);
        tick(); settle();
        chk("seq0_addr", imem_addr, 32'h0);
        chk("seq0_req", 32'(imem_req), 1);
        chk("seq0_next", pc_next, 32'h4);
        chk("seq0_fv", 32'(fetch_valid), 1);
        tick(); settle();
        chk("seq1_next", pc_next, 32'h8);
        tick(); settle();
        chk("seq2_next", pc_next, 32'hC);
        chk("seq2_fv", 32'(fetch_valid), 1);

        // Slow memory at 0x10 with a branch landing while the fetch is outstanding.
        tick(); jmp_valid = 1'b1; jmp_target = 32'h10; settle();
        chk("jmp10_next", pc_next, 32'h10);
        chk("jmp10_fv", 32'(fetch_valid), 0);
        tick(); jmp_valid = 1'b0; imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h40; settle();
        chk("slow_addr", imem_addr, 32'h10);
        chk("slow_c1_ena", 32'(pc_ena), 0);
        tick(); br_taken = 1'b0; settle();
        chk("slow_c2_ena", 32'(pc_ena), 0);
        chk("slow_c2_req", 32'(imem_req), 1);
        tick(); settle();
        chk("slow_c3_ena", 32'(pc_ena), 0);
        tick(); imem_ack = 1'b1; settle();
        chk("slow_ack_ena", 32'(pc_ena), 1);
        chk("slow_ack_next", pc_next, 32'h40);
        chk("slow_ack_fv", 32'(fetch_valid), 0);
        tick(); settle();
        chk("after_br_next", pc_next, 32'h44);
        chk("after_br_fv", 32'(fetch_valid), 1);

        // Priority: exc beats jmp/br, and a pending exc is not overwritten.
        tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h100;
        jmp_valid = 1'b1; jmp_target = 32'h200; exc_req = 1'b1; settle();
        chk("prio_noack_ena", 32'(pc_ena), 0);
        tick(); br_taken = 1'b0; exc_req = 1'b0; jmp_target = 32'h300; settle();
        chk("prio_jmp_ena", 32'(pc_ena), 0);
        tick(); jmp_valid = 1'b0; imem_ack = 1'b1; settle();
        chk("prio_exc_next", pc_next, 32'h4);
        chk("prio_exc_fv", 32'(fetch_valid), 0);

        // A pending jump is replaced by a later branch.
        tick(); imem_ack = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h200; settle();
        tick(); jmp_valid = 1'b0; imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h100; settle();
        chk("ovr_br_next", pc_next, 32'h100);

        // Stall at 0x20 for four cycles.
        tick(); br_taken = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h20; settle();
        chk("jmp20_next", pc_next, 32'h20);
        tick(); jmp_valid = 1'b0; stall = 1'b1; settle();
        chk("stall_ack_ena", 32'(pc_ena), 0);
        chk("stall_ack_fv", 32'(fetch_valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); imem_ack = 1'b0; settle();
            chk("stall_req", 32'(imem_req), 0);
            chk("stall_ena", 32'(pc_ena), 0);
        end
        tick(); stall = 1'b0; settle();
        chk("unstall_fv", 32'(fetch_valid), 1);
        chk("unstall_next", pc_next, 32'h24);

        // Redirect beats stall.
        tick(); imem_ack = 1'b1; stall = 1'b1; settle();
        tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h80; settle();
        chk("stall_br_next", pc_next, 32'h80);
        chk("stall_br_fv", 32'(fetch_valid), 0);

        // Wrap and alignment.
        tick(); br_taken = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC; settle();
        tick(); jmp_valid = 1'b0; settle();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_next", pc_next, 32'h0);
        tick(); jmp_valid = 1'b1; jmp_target = 32'h0000_0103; settle();
        chk("align_next", pc_next, 32'h0000_0100);

        // Halt at an instruction boundary, then exit via exception.
        tick(); jmp_valid = 1'b0; imem_ack = 1'b0; halt = 1'b1; settle();
        chk("halt_wait", 32'(halted), 0);
        tick(); imem_ack = 1'b1; settle();
        chk("halt_fv", 32'(fetch_valid), 1);
        chk("halt_last_next", pc_next, 32'h104);
        tick(); jmp_valid = 1'b1; jmp_target = 32'h500; settle();
        chk("halted", 32'(halted), 1);
        chk("halted_req", 32'(imem_req), 0);
        chk("halted_ena", 32'(pc_ena), 0);
        tick(); jmp_valid = 1'b0; exc_req = 1'b1; settle();
        chk("halt_exc_ena", 32'(pc_ena), 1);
        chk("halt_exc_next", pc_next, 32'h4);
        tick(); exc_req = 1'b0; halt = 1'b0; settle();
        chk("post_halt", 32'(halted), 0);
        chk("post_halt_addr", imem_addr, 32'h4);

        // Reset while a redirect is pending.
        imem_ack = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h200; settle();
        tick(); jmp_valid = 1'b0; rst = 1'b0; imem_ack = 1'b1; settle();
        chk("mid_rst_ena", 32'(pc_ena), 0);
        chk("mid_rst_req", 32'(imem_req), 0);
        chk("mid_rst_next", pc_next, 32'h0);
        tick(); rst = 1'b1; settle();
        chk("reboot_ena", 32'(pc_ena), 1);
        chk("reboot_next", pc_next, 32'h0);
        tick(); settle();
        chk("reboot_seq_next", pc_next, 32'h4);
        chk("reboot_seq_fv", 32'(fetch_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
